// File: rtl/template_pkg.sv
// rtl/template_pkg.sv - state encoding and default sizes shared by the template grabber files
package template_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURING,
        DONE
    } tg_state_e;

    localparam int TG_TPL_W      = 16;
    localparam int TG_TPL_H      = 16;
    localparam int TG_PIX_W      = 4;
    localparam int TG_DECIM_LOG2 = 1;
    localparam int TG_COORD_W    = 10;

endpackage

// File: rtl/tg_window_map.sv
// rtl/tg_window_map.sv - maps a live pixel coordinate onto the latched template window
module tg_window_map
    import template_pkg::*;
#(
    parameter int TPL_W      = TG_TPL_W,
    parameter int TPL_H      = TG_TPL_H,
    parameter int DECIM_LOG2 = TG_DECIM_LOG2,
    parameter int COORD_W    = TG_COORD_W,
    localparam int CW        = $clog2(TPL_W),
    localparam int RW        = $clog2(TPL_H)
) (
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [COORD_W-1:0] box_left,
    input  logic [COORD_W-1:0] box_top,
    output logic               hit,
    output logic [CW-1:0]      col,
    output logic [RW-1:0]      row
);

    localparam int DW = COORD_W + 1;
    localparam logic [DW-1:0] SPAN_X   = DW'(TPL_W << DECIM_LOG2);
    localparam logic [DW-1:0] SPAN_Y   = DW'(TPL_H << DECIM_LOG2);
    localparam logic [DW-1:0] LOW_MASK = DW'((1 << DECIM_LOG2) - 1);

    logic [DW-1:0] dx;
    logic [DW-1:0] dy;

    // The extra top bit makes a pixel left of / above the box wrap to a huge offset, i.e. a miss
    assign dx = {1'b0, pix_x} - {1'b0, box_left};
    assign dy = {1'b0, pix_y} - {1'b0, box_top};

    assign hit = pix_valid
              && (dx < SPAN_X) && (dy < SPAN_Y)
              && ((dx & LOW_MASK) == '0) && ((dy & LOW_MASK) == '0);

    assign col = CW'(dx >> DECIM_LOG2);
    assign row = RW'(dy >> DECIM_LOG2);

endmodule

// File: rtl/template_grabber.sv
// rtl/template_grabber.sv - template capture engine; TEMPLATE_MEAN_EN adds the tpl_mean output
module template_grabber
    import template_pkg::*;
#(
    parameter int TPL_W      = TG_TPL_W,
    parameter int TPL_H      = TG_TPL_H,
    parameter int PIX_W      = TG_PIX_W,
    parameter int DECIM_LOG2 = TG_DECIM_LOG2,
    parameter int COORD_W    = TG_COORD_W,
    localparam int CW        = $clog2(TPL_W),
    localparam int RW        = $clog2(TPL_H)
) (
    input  logic                         GCLK,
    input  logic                         reset,
    input  logic                         arm,
    input  logic                         abort,
    input  logic [COORD_W-1:0]           box_left,
    input  logic [COORD_W-1:0]           box_top,
    input  logic                         sof,
    input  logic                         eof,
    input  logic                         pix_valid,
    input  logic [COORD_W-1:0]           pix_x,
    input  logic [COORD_W-1:0]           pix_y,
    input  logic [PIX_W-1:0]             pix_data,
    output logic                         busy,
    output logic                         done,
    output logic                         tpl_valid,
    output logic                         tpl_partial,
    input  logic [CW-1:0]                rd_x,
    input  logic [RW-1:0]                rd_y,
    output logic [PIX_W-1:0]             rd_data,
    output logic [TPL_W*TPL_H*PIX_W-1:0] tpl_flat
`ifdef TEMPLATE_MEAN_EN
    ,
    output logic [PIX_W-1:0]             tpl_mean
`endif
);

    localparam int N     = TPL_W * TPL_H;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(N);

    tg_state_e          state_q, state_d;
    logic [COORD_W-1:0] left_q, left_d;
    logic [COORD_W-1:0] top_q, top_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic               partial_q, partial_d;
    logic [PIX_W-1:0]   tpl_q [TPL_H][TPL_W];
    logic [PIX_W-1:0]   tpl_d [TPL_H][TPL_W];

    logic               hit;
    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic               capture;
    logic               enter_arm;
    logic               cancel;

`ifdef TEMPLATE_MEAN_EN
    localparam int SUM_W = PIX_W + $clog2(N + 1);
    localparam bit N_POW2 = (N & (N - 1)) == 0;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [PIX_W-1:0] mean_q, mean_d;
`endif

    tg_window_map #(
        .TPL_W      (TPL_W),
        .TPL_H      (TPL_H),
        .DECIM_LOG2 (DECIM_LOG2),
        .COORD_W    (COORD_W)
    ) u_map (
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .box_left  (left_q),
        .box_top   (top_q),
        .hit       (hit),
        .col       (col),
        .row       (row)
    );

    always_comb begin
        state_d   = state_q;
        left_d    = left_q;
        top_d     = top_q;
        count_d   = count_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        partial_d = partial_q;
        tpl_d     = tpl_q;
        capture   = 1'b0;
        enter_arm = 1'b0;
        cancel    = 1'b0;
`ifdef TEMPLATE_MEAN_EN
        sum_d     = sum_q;
        mean_d    = mean_q;
`endif

        case (state_q)
            IDLE:      if (arm && !abort) enter_arm = 1'b1;
            ARMED: begin
                if (abort) begin
                    cancel = 1'b1;
                end else if (sof) begin
                    state_d = CAPTURING;
                    capture = 1'b1;
                end
            end
            CAPTURING: begin
                if (abort) cancel = 1'b1;
                else       capture = 1'b1;
            end
            DONE: begin
                if (abort)    cancel = 1'b1;
                else if (arm) enter_arm = 1'b1;
            end
            default:   state_d = IDLE;
        endcase

        if (enter_arm) begin
            state_d = ARMED;
            left_d  = box_left;
            top_d   = box_top;
        end
        if (cancel) state_d = IDLE;
        if (enter_arm || cancel) begin
            count_d   = '0;
            valid_d   = 1'b0;
            partial_d = 1'b0;
`ifdef TEMPLATE_MEAN_EN
            sum_d     = '0;
            mean_d    = '0;
`endif
        end

        if (capture) begin
            if (hit) begin
                tpl_d[row][col] = pix_data;
                count_d         = count_q + 1'b1;
`ifdef TEMPLATE_MEAN_EN
                sum_d           = sum_q + SUM_W'(pix_data);
`endif
            end
            // A final write coinciding with eof still counts as a complete capture
            if (count_d == FULL || eof) begin
                state_d   = DONE;
                done_d    = 1'b1;
                valid_d   = (count_d == FULL);
                partial_d = (count_d != FULL);
`ifdef TEMPLATE_MEAN_EN
                mean_d    = N_POW2 ? PIX_W'(sum_d >> $clog2(N))
                                   : PIX_W'(sum_d / SUM_W'(N));
`endif
            end
        end
    end

    always_ff @(posedge GCLK) begin
        if (reset) begin
            state_q   <= IDLE;
            left_q    <= '0;
            top_q     <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            partial_q <= 1'b0;
            tpl_q     <= '{default: '0};
`ifdef TEMPLATE_MEAN_EN
            sum_q     <= '0;
            mean_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            left_q    <= left_d;
            top_q     <= top_d;
            count_q   <= count_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            partial_q <= partial_d;
            tpl_q     <= tpl_d;
`ifdef TEMPLATE_MEAN_EN
            sum_q     <= sum_d;
            mean_q    <= mean_d;
`endif
        end
    end

    assign busy        = (state_q == ARMED) || (state_q == CAPTURING);
    assign done        = done_q;
    assign tpl_valid   = valid_q;
    assign tpl_partial = partial_q;
    assign rd_data     = tpl_q[rd_y][rd_x];
`ifdef TEMPLATE_MEAN_EN
    assign tpl_mean    = mean_q;
`endif

    always_comb begin
        tpl_flat = '0;
        for (int r = 0; r < TPL_H; r++) begin
            for (int c = 0; c < TPL_W; c++) begin
                tpl_flat[(r*TPL_W + c)*PIX_W +: PIX_W] = tpl_q[r][c];
            end
        end
    end

endmodule

// File: tb/tb_template_grabber.sv
// tb/tb_template_grabber.sv - scoreboard bench for template_grabber, 4x4 template with 2x decimation
module tb_template_grabber;

    localparam int TPL_W = 4, TPL_H = 4, PIX_W = 4, DECIM_LOG2 = 1, COORD_W = 10;

    logic        GCLK = 1'b0;
    logic        reset = 1'b1, arm = 1'b0, abort = 1'b0;
    logic        sof = 1'b0, eof = 1'b0, pix_valid = 1'b0;
    logic [9:0]  box_left = '0, box_top = '0, pix_x = '0, pix_y = '0;
    logic [3:0]  pix_data = '0;
    logic [1:0]  rd_x = '0, rd_y = '0;
    logic        busy, done, tpl_valid, tpl_partial;
    logic [3:0]  rd_data;
    logic [63:0] tpl_flat;
`ifdef TEMPLATE_MEAN_EN
    logic [3:0]  tpl_mean;
`endif

    template_grabber #(
        .TPL_W(TPL_W), .TPL_H(TPL_H), .PIX_W(PIX_W), .DECIM_LOG2(DECIM_LOG2), .COORD_W(COORD_W)
    ) dut (
        .GCLK(GCLK), .reset(reset), .arm(arm), .abort(abort),
        .box_left(box_left), .box_top(box_top), .sof(sof), .eof(eof),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .busy(busy), .done(done), .tpl_valid(tpl_valid), .tpl_partial(tpl_partial),
        .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .tpl_flat(tpl_flat)
`ifdef TEMPLATE_MEAN_EN
        , .tpl_mean(tpl_mean)
`endif
    );

    always #5 GCLK = ~GCLK;

    int cyc = 0;
    always @(posedge GCLK) cyc <= cyc + 1;

    typedef struct {
        int          cycle;
        logic        valid;
        logic        partial;
        logic [63:0] flat;
        logic [3:0]  mean;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [3:0] pixval(input int mode, input int k, input int x, input int y);
        case (mode)
            1:       return 4'(k);
            2:       return ((((x >> 1) + (y >> 1)) & 1) != 0) ? 4'hF : 4'h0;
            default: return 4'(x + y + k);
        endcase
    endfunction

    // Expected array after a complete capture at box (bl,bt): cell (r,c) sits at frame (bl+2c, bt+2r)
    function automatic logic [63:0] full_flat(input int mode, input int k, input int bl, input int bt);
        logic [63:0] f = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                f[(r*4 + c)*4 +: 4] = pixval(mode, k, bl + 2*c, bt + 2*r);
        return f;
    endfunction

    function automatic logic [3:0] flat_mean(input logic [63:0] f);
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'(f[i*4 +: 4]);
        return 4'(s / 16);
    endfunction

    task automatic push_exp(input int cycle, input logic v, input logic p,
                            input logic [63:0] f, input logic [3:0] m);
        exp_t e;
        e.cycle = cycle; e.valid = v; e.partial = p; e.flat = f; e.mean = m;
        sb.push_back(e);
    endtask

    task automatic arm_box(input int l, input int t);
        box_left = 10'(l); box_top = 10'(t); arm = 1'b1;
        @(posedge GCLK); #1;
        arm = 1'b0; box_left = 10'h3FF; box_top = 10'h3FF;
    endtask

    // stop_kind: 0 none, 1 abort at pixel stop_at, 2 reset at pixel stop_at
    task automatic drive_frame(input int x0, input int x1, input int y0, input int y1,
                               input int mode, input int k, input int stop_at,
                               input int stop_kind, input int arm_at);
        int idx = 0;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
                pix_data = pixval(mode, k, x, y);
                sof = (idx == 0);
                arm = (idx == arm_at);
                if (idx == arm_at) begin box_left = '0; box_top = '0; end
                abort = (stop_kind == 1 && idx == stop_at);
                reset = (stop_kind == 2 && idx == stop_at);
                @(posedge GCLK); #1;
                arm = 1'b0; abort = 1'b0; reset = 1'b0;
                if (idx == stop_at) begin
                    pix_valid = 1'b0; sof = 1'b0;
                    return;
                end
                idx++;
            end
        end
        pix_valid = 1'b0; sof = 1'b0; eof = 1'b1;
        @(posedge GCLK); #1;
        eof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge GCLK);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge GCLK);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.cycle));
                    check("tpl_valid", 64'(tpl_valid), 64'(e.valid));
                    check("tpl_partial", 64'(tpl_partial), 64'(e.partial));
                    check("tpl_flat", tpl_flat, e.flat);
`ifdef TEMPLATE_MEAN_EN
                    check("tpl_mean", 64'(tpl_mean), 64'(e.mean));
`endif
                end
            end
        end
    end

    initial begin
        logic [63:0] f1, f2, f;
        int start;

        @(posedge GCLK); #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(tpl_valid), 64'd0);
        check("rst_partial", 64'(tpl_partial), 64'd0);
        check("rst_flat", tpl_flat, 64'd0);
        idle(2);
        reset = 1'b0;
        idle(2);

        // 1: full decimated capture; last hit (16,26) is raster index 26*32+16 = 848
        arm_box(10, 20);
        check("arm_busy", 64'(busy), 64'd1);
        f1 = full_flat(0, 0, 10, 20);
        start = cyc;
        push_exp(start + 849, 1'b1, 1'b0, f1, flat_mean(f1));
        drive_frame(0, 31, 0, 31, 0, 0, -1, 0, -1);
        idle(3);
        rd_x = 2'd0; rd_y = 2'd0; #1;
        check("rd_0_0", 64'(rd_data), 64'd14);
        rd_x = 2'd1; rd_y = 2'd2; #1;
        check("rd_2_1", 64'(rd_data), 64'd4);
        rd_x = 2'd3; rd_y = 2'd3; #1;
        check("rd_3_3", 64'(rd_data), 64'd10);

        // 2: window past frame corner; only (638,478) -> cell 0,0 = 1116&15 = 12, eof at index 100
        arm_box(638, 478);
        check("rearm_valid_clr", 64'(tpl_valid), 64'd0);
        f2 = {f1[63:4], 4'd12};
        start = cyc;
        push_exp(start + 101, 1'b0, 1'b1, f2, 4'd0);
        drive_frame(630, 639, 470, 479, 0, 0, -1, 0, -1);
        idle(3);

        // 3: abort mid-capture, then a clean re-arm
        arm_box(10, 20);
        check("arm_partial_clr", 64'(tpl_partial), 64'd0);
        drive_frame(0, 31, 0, 31, 0, 3, 700, 1, -1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(tpl_valid), 64'd0);
        idle(20);
        arm_box(10, 20);
        f = full_flat(0, 5, 10, 20);
        start = cyc;
        push_exp(start + 849, 1'b1, 1'b0, f, flat_mean(f));
        drive_frame(0, 31, 0, 31, 0, 5, -1, 0, -1);
        idle(3);

        // 4: abort from DONE, arm+abort in IDLE, arm ignored while capturing
        abort = 1'b1; @(posedge GCLK); #1; abort = 1'b0;
        check("done_abort_valid", 64'(tpl_valid), 64'd0);
        check("done_abort_busy", 64'(busy), 64'd0);
        box_left = '0; box_top = '0; arm = 1'b1; abort = 1'b1;
        @(posedge GCLK); #1;
        arm = 1'b0; abort = 1'b0;
        check("arm_abort_busy", 64'(busy), 64'd0);
        drive_frame(0, 31, 0, 31, 0, 1, -1, 0, -1);
        idle(3);
        arm_box(10, 20);
        f = full_flat(0, 7, 10, 20);
        start = cyc;
        push_exp(start + 849, 1'b1, 1'b0, f, flat_mean(f));
        drive_frame(0, 31, 0, 31, 0, 7, -1, 0, 100);
        idle(3);

        // 5: reset during capture
        arm_box(10, 20);
        drive_frame(0, 31, 0, 31, 0, 9, 700, 2, -1);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_valid", 64'(tpl_valid), 64'd0);
        check("mrst_partial", 64'(tpl_partial), 64'd0);
        check("mrst_flat", tpl_flat, 64'd0);
        idle(5);

`ifdef TEMPLATE_MEAN_EN
        // 6: mean of uniform 9s and of a 0/F checkerboard (120/16 -> 7)
        arm_box(10, 20);
        start = cyc;
        push_exp(start + 849, 1'b1, 1'b0, 64'h9999_9999_9999_9999, 4'd9);
        drive_frame(0, 31, 0, 31, 1, 9, -1, 0, -1);
        idle(3);
        arm_box(10, 20);
        check("arm_mean_clr", 64'(tpl_mean), 64'd0);
        start = cyc;
        push_exp(start + 849, 1'b1, 1'b0, full_flat(2, 0, 10, 20), 4'd7);
        drive_frame(0, 31, 0, 31, 2, 0, -1, 0, -1);
        idle(3);
`endif

        idle(5);
        while (sb.size() > 0) begin
            e_drop();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic e_drop();
        exp_t e;
        e = sb.pop_front();
        check("missing_done", 64'd0, 64'(e.cycle));
    endtask

endmodule
